// File: rtl/axi_wr_arbiter_if.sv
// rtl/axi_wr_arbiter_if.sv - handshake bundle between NUM_MST AXI write masters, the arbiter and one slave
//
// Purpose:
//   Carries the valid/ready steering signals of the shared AW/W/B write path together with the
//   grant outputs.  Payload (IDs, addresses, data, strobes, responses) is muxed outside the
//   arbiter on gnt_idx and is therefore not part of this bundle.
//
// Modports:
//   slave  - arbiter view: accepts requests from the masters, drives the shared slave path
//   master - environment view: the NUM_MST upstream masters plus the downstream slave
//
// Signals (m_* are per-master vectors, master i at bit i or slice [i*W +: W]):
//   m_awvalid/m_awlen/m_awready, m_wvalid/m_wlast/m_wready, m_bvalid/m_bready
//   s_awvalid/s_awready, s_wvalid/s_wlast/s_wready, s_bvalid/s_bready
//   gnt_onehot, gnt_idx, busy, err_wlast
//
// Optional feature macro: AXI_ARB_QOS_EN adds m_awqos (4 bits per master).

interface axi_wr_arbiter_if #(
   parameter int NUM_MST   = 4,
   parameter int LEN_WIDTH = 8,
   parameter int IDX_W     = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
);
   logic [NUM_MST-1:0]           m_awvalid;
   logic [NUM_MST*LEN_WIDTH-1:0] m_awlen;
   logic [NUM_MST-1:0]           m_awready;
`ifdef AXI_ARB_QOS_EN
   logic [NUM_MST*4-1:0]         m_awqos;
`endif
   logic [NUM_MST-1:0]           m_wvalid;
   logic [NUM_MST-1:0]           m_wlast;
   logic [NUM_MST-1:0]           m_wready;
   logic [NUM_MST-1:0]           m_bvalid;
   logic [NUM_MST-1:0]           m_bready;

   logic                         s_awvalid;
   logic                         s_awready;
   logic                         s_wvalid;
   logic                         s_wlast;
   logic                         s_wready;
   logic                         s_bvalid;
   logic                         s_bready;

   logic [NUM_MST-1:0]           gnt_onehot;
   logic [IDX_W-1:0]             gnt_idx;
   logic                         busy;
   logic                         err_wlast;

   modport slave (
`ifdef AXI_ARB_QOS_EN
      input  m_awqos,
`endif
      input  m_awvalid, m_awlen, m_wvalid, m_wlast, m_bready,
      input  s_awready, s_wready, s_bvalid,
      output m_awready, m_wready, m_bvalid,
      output s_awvalid, s_wvalid, s_wlast, s_bready,
      output gnt_onehot, gnt_idx, busy, err_wlast
   );

   modport master (
`ifdef AXI_ARB_QOS_EN
      output m_awqos,
`endif
      output m_awvalid, m_awlen, m_wvalid, m_wlast, m_bready,
      output s_awready, s_wready, s_bvalid,
      input  m_awready, m_wready, m_bvalid,
      input  s_awvalid, s_wvalid, s_wlast, s_bready,
      input  gnt_onehot, gnt_idx, busy, err_wlast
   );
endinterface

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - round-robin arbiter sharing one AXI write path between NUM_MST masters
//
// Purpose:
//   One write transaction at a time.  A master is picked in IDLE (round-robin from rr_ptr),
//   its AW is forwarded in ADDR, its W beats in DATA and the slave's B is routed back in RESP.
//   The grant is held from IDLE exit until the B handshake; rr_ptr then moves past the winner.
//   Each W burst is checked against the granted AWLEN; any mismatch sets the sticky err_wlast.
//
// Ports:
//   AXI_ACLK    in  clock, rising edge
//   AXI_ARESET  in  asynchronous, active-high reset; aborts any transaction in flight
//   bus         axi_wr_arbiter_if.slave: per-master AW/W/B handshakes, shared slave handshakes,
//               gnt_onehot/gnt_idx (registered grant), busy (not IDLE), err_wlast (sticky)
//
// Optional feature macro: AXI_ARB_QOS_EN
//   When defined, only requesters at the highest m_awqos compete in the round-robin search.

module axi_wr_arbiter #(
   parameter int NUM_MST   = 4,
   parameter int LEN_WIDTH = 8,
   parameter int IDX_W     = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
   input  logic           AXI_ACLK,
   input  logic           AXI_ARESET,
   axi_wr_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_MST-1:0]   gnt_onehot_q, gnt_onehot_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [LEN_WIDTH-1:0] exp_len_q, exp_len_d;
   logic                 err_wlast_q, err_wlast_d;

   // ---------------------------------------------------------------------------------------
   // Eligible requesters
   // ---------------------------------------------------------------------------------------
   logic [NUM_MST-1:0]   req_elig;

`ifdef AXI_ARB_QOS_EN
   // Only masters sharing the highest requested QoS level stay in the round-robin search.
   always_comb begin : qos_filter
      logic [3:0] max_qos;
      max_qos  = '0;
      req_elig = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (bus.m_awvalid[i] && (bus.m_awqos[i*4 +: 4] > max_qos)) begin
            max_qos = bus.m_awqos[i*4 +: 4];
         end
      end
      for (int i = 0; i < NUM_MST; i++) begin
         req_elig[i] = bus.m_awvalid[i] && (bus.m_awqos[i*4 +: 4] == max_qos);
      end
   end
`else
   assign req_elig = bus.m_awvalid;
`endif

   // ---------------------------------------------------------------------------------------
   // Round-robin winner
   // ---------------------------------------------------------------------------------------
   // Rotating the doubled request vector right by rr_ptr puts master (rr_ptr+k) mod NUM_MST
   // at bit k, so the lowest set bit of the rotated vector is the winner.
   logic [2*NUM_MST-1:0] req_dbl;
   logic [NUM_MST-1:0]   req_rot;
   logic [NUM_MST-1:0]   win_onehot;
   logic [IDX_W-1:0]     win_idx;
   logic [LEN_WIDTH-1:0] win_len;
   logic [LEN_WIDTH-1:0] gnt_len;
   logic                 win_found;

   assign req_dbl   = {req_elig, req_elig} >> rr_ptr_q;
   assign req_rot   = req_dbl[NUM_MST-1:0];
   assign win_found = |req_elig;

   // Scanned from the top so the lowest rotated position is the last (winning) assignment.
   always_comb begin : rr_pick
      int pos;
      pos        = 0;
      win_idx    = '0;
      win_onehot = '0;
      for (int k = NUM_MST - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            pos = k + int'(rr_ptr_q);
            if (pos >= NUM_MST) begin
               pos = pos - NUM_MST;
            end
            win_idx    = IDX_W'(pos);
            win_onehot = NUM_MST'(1) << pos;
         end
      end
   end

   always_comb begin : win_len_sel
      win_len = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (win_onehot[i]) begin
            win_len = bus.m_awlen[i*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   always_comb begin : gnt_len_sel
      gnt_len = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (gnt_onehot_q[i]) begin
            gnt_len = bus.m_awlen[i*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Routed handshakes of the granted master
   // ---------------------------------------------------------------------------------------
   logic aw_vld_g;
   logic w_vld_g;
   logic w_last_g;
   logic b_rdy_g;

   assign aw_vld_g = |(bus.m_awvalid & gnt_onehot_q);
   assign w_vld_g  = |(bus.m_wvalid  & gnt_onehot_q);
   assign w_last_g = |(bus.m_wlast   & gnt_onehot_q);
   assign b_rdy_g  = |(bus.m_bready  & gnt_onehot_q);

   // ---------------------------------------------------------------------------------------
   // FSM next state and steering outputs
   // ---------------------------------------------------------------------------------------
   always_comb begin : fsm_next
      state_d        = state_q;
      gnt_onehot_d   = gnt_onehot_q;
      gnt_idx_d      = gnt_idx_q;
      rr_ptr_d       = rr_ptr_q;
      beat_cnt_d     = beat_cnt_q;
      exp_len_d      = exp_len_q;
      err_wlast_d    = err_wlast_q;

      bus.m_awready  = '0;
      bus.m_wready   = '0;
      bus.m_bvalid   = '0;
      bus.s_awvalid  = 1'b0;
      bus.s_wvalid   = 1'b0;
      bus.s_wlast    = 1'b0;
      bus.s_bready   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               gnt_onehot_d = win_onehot;
               gnt_idx_d    = win_idx;
               exp_len_d    = win_len;
               state_d      = ST_ADDR;
            end
         end

         ST_ADDR: begin
            bus.s_awvalid = aw_vld_g;
            bus.m_awready = gnt_onehot_q & {NUM_MST{bus.s_awready}};
            // AWLEN is only guaranteed stable while AWVALID is up, so take it again here.
            exp_len_d     = gnt_len;
            if (aw_vld_g && bus.s_awready) begin
               beat_cnt_d = '0;
               state_d    = ST_DATA;
            end
         end

         ST_DATA: begin
            bus.s_wvalid = w_vld_g;
            bus.s_wlast  = w_last_g;
            bus.m_wready = gnt_onehot_q & {NUM_MST{bus.s_wready}};
            if (w_vld_g && bus.s_wready) begin
               if (beat_cnt_q != '1) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
               if (w_last_g) begin
                  state_d = ST_RESP;
                  if (beat_cnt_q != exp_len_q) begin
                     err_wlast_d = 1'b1;
                  end
               end else if (beat_cnt_q == exp_len_q) begin
                  // Expected last beat arrived without WLAST; keep draining until WLAST.
                  err_wlast_d = 1'b1;
               end
            end
         end

         ST_RESP: begin
            bus.m_bvalid = gnt_onehot_q & {NUM_MST{bus.s_bvalid}};
            bus.s_bready = b_rdy_g;
            if (bus.s_bvalid && b_rdy_g) begin
               rr_ptr_d     = (gnt_idx_q == IDX_W'(NUM_MST - 1)) ? '0 : gnt_idx_q + 1'b1;
               gnt_onehot_d = '0;
               state_d      = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin : fsm_regs
      if (AXI_ARESET) begin
         state_q      <= ST_IDLE;
         gnt_onehot_q <= '0;
         gnt_idx_q    <= '0;
         rr_ptr_q     <= '0;
         beat_cnt_q   <= '0;
         exp_len_q    <= '0;
         err_wlast_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_onehot_q <= gnt_onehot_d;
         gnt_idx_q    <= gnt_idx_d;
         rr_ptr_q     <= rr_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         exp_len_q    <= exp_len_d;
         err_wlast_q  <= err_wlast_d;
      end
   end

   assign bus.gnt_onehot = gnt_onehot_q;
   assign bus.gnt_idx    = gnt_idx_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.err_wlast  = err_wlast_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - randomized scoreboard bench for axi_wr_arbiter
`timescale 1ns/1ps

module tb_axi_wr_arbiter;
   localparam int N  = 4;
   localparam int LW = 8;

   typedef struct {
      int idx;
      int len;
      int last;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_wr_arbiter_if #(.NUM_MST(N), .LEN_WIDTH(LW)) bus ();

   axi_wr_arbiter #(.NUM_MST(N), .LEN_WIDTH(LW)) dut (
      .AXI_ACLK   (clk),
      .AXI_ARESET (rst),
      .bus        (bus)
   );

   // Scoreboard and environment state
   txn_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   aw_pend[N];
   bit   w_part[N];
   int   beats[N];
   int   len_m[N];
   int   last_m[N];
   int   qos_m[N];
   int   rr_model = 0;
   bit   err_model = 1'b0;
   int   outstanding = 0;
   bit   b_pend = 1'b0;
   int   b_delay = 0;
   int   b_fixed = -1;
   int   aw_stall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference arbitration: highest QoS among pending, then first at or after rr wrapping.
   function automatic int pick(input logic [N-1:0] pend, input int rr, input int qos[N]);
      int best_q = -1;
      for (int i = 0; i < N; i++) begin
         if (pend[i] && qos[i] > best_q) best_q = qos[i];
      end
      for (int k = 0; k < N; k++) begin
         int i = (rr + k) % N;
         if (pend[i] && qos[i] == best_q) return i;
      end
      return -1;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt_onehot"}, bus.gnt_onehot, 0);
      check({tag, "_gnt_idx"},    bus.gnt_idx, 0);
      check({tag, "_busy"},       bus.busy, 0);
      check({tag, "_err_wlast"},  bus.err_wlast, 0);
      check({tag, "_s_out"},      {bus.s_awvalid, bus.s_wvalid, bus.s_wlast, bus.s_bready}, 0);
      check({tag, "_m_out"},      {bus.m_awready, bus.m_wready, bus.m_bvalid}, 0);
   endtask

   // Masters and slave: drive at negedge, book-keep handshakes 1 ns later.
   initial begin : driver
      bus.m_awvalid = '0;
      bus.m_awlen   = '0;
      bus.m_wvalid  = '0;
      bus.m_wlast   = '0;
      bus.m_bready  = '0;
      bus.s_awready = 1'b0;
      bus.s_wready  = 1'b0;
      bus.s_bvalid  = 1'b0;
`ifdef AXI_ARB_QOS_EN
      bus.m_awqos   = '0;
`endif
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            bus.m_awvalid[i]           = aw_pend[i];
            bus.m_awlen[i*LW +: LW]    = LW'(len_m[i]);
            bus.m_wvalid[i]            = ($urandom_range(0, 3) != 0);
            bus.m_wlast[i]             = w_part[i] ? (beats[i] == last_m[i]) : ($urandom_range(0, 1) == 1);
            bus.m_bready[i]            = ($urandom_range(0, 3) != 0);
`ifdef AXI_ARB_QOS_EN
            bus.m_awqos[i*4 +: 4]      = 4'(qos_m[i]);
`endif
         end
         bus.s_awready = (aw_stall == 0) && ($urandom_range(0, 3) != 0);
         if (aw_stall > 0) aw_stall--;
         bus.s_wready  = ($urandom_range(0, 2) != 0);
         bus.s_bvalid  = b_pend && (b_delay == 0);
         if (b_pend && b_delay > 0) b_delay--;
         #1;
         if (!rst) begin
            for (int i = 0; i < N; i++) begin
               if (bus.m_awvalid[i] && bus.m_awready[i]) aw_pend[i] = 1'b0;
               if (bus.m_wvalid[i] && bus.m_wready[i] && w_part[i]) begin
                  if (bus.m_wlast[i]) w_part[i] = 1'b0;
                  else beats[i]++;
               end
               if (bus.m_bvalid[i] && bus.m_bready[i]) outstanding--;
            end
            if (bus.s_wvalid && bus.s_wready && bus.s_wlast) begin
               b_pend  = 1'b1;
               b_delay = (b_fixed >= 0) ? b_fixed : int'($urandom_range(0, 3));
            end
            if (bus.s_bvalid && bus.s_bready) b_pend = 1'b0;
         end
      end
   end

   // Monitor: pops the expected transaction on each routed B handshake.
   initial begin : monitor
      int            w_seen;
      logic [N-1:0]  allowed;
      logic [N-1:0]  b_hs;
      txn_t          t;
      w_seen = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            w_seen = 0;
         end else begin
            allowed = (exp_q.size() > 0) ? (N'(1) << exp_q[0].idx) : '0;
            check("stray_route", (bus.m_awready | bus.m_wready | bus.m_bvalid) & ~allowed, 0);
            if (bus.s_awvalid && bus.s_awready) begin
               if (exp_q.size() == 0) begin
                  check("aw_unexpected", 1, 0);
               end else begin
                  check("aw_gnt_idx", bus.gnt_idx, exp_q[0].idx);
                  check("aw_gnt_onehot", bus.gnt_onehot, N'(1) << exp_q[0].idx);
               end
            end
            if (bus.s_wvalid && bus.s_wready) w_seen++;
            b_hs = bus.m_bvalid & bus.m_bready;
            if (b_hs != '0) begin
               if (exp_q.size() == 0) begin
                  check("b_unexpected", b_hs, 0);
               end else begin
                  t = exp_q.pop_front();
                  err_model = err_model | (t.last != t.len);
                  check("b_route", bus.m_bvalid, N'(1) << t.idx);
                  check("b_gnt_onehot", bus.gnt_onehot, N'(1) << t.idx);
                  check("w_beats", w_seen, t.last + 1);
                  check("err_wlast", bus.err_wlast, err_model);
                  check("busy_in_resp", bus.busy, 1);
               end
               w_seen = 0;
            end
         end
      end
   end

   task automatic start_round(input logic [N-1:0] mask, input int lens[N], input int lasts[N],
                              input int qos[N]);
      logic [N-1:0] pend;
      int           w;
      txn_t         t;
      @(posedge clk);
      #1;
      pend = mask;
      outstanding = 0;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            len_m[i]  = lens[i];
            last_m[i] = lasts[i];
            qos_m[i]  = qos[i];
            beats[i]  = 0;
            w_part[i] = 1'b1;
            aw_pend[i] = 1'b1;
            outstanding++;
         end
      end
      while (pend != '0) begin
         w = pick(pend, rr_model, qos);
         t.idx = w;
         t.len = lens[w];
         t.last = lasts[w];
         exp_q.push_back(t);
         pend[w] = 1'b0;
         rr_model = (w + 1) % N;
      end
   endtask

   task automatic finish_round();
      int guard = 0;
      while (outstanding > 0 && guard < 3000) begin
         @(posedge clk);
         guard++;
      end
      checks++;
      if (outstanding > 0) begin
         errors++;
         $display("FAIL round_timeout outstanding=%0d expected=0", outstanding);
      end
      #2;
      check("queue_drained", exp_q.size(), 0);
      check("idle_after_round", bus.busy, 0);
   endtask

   task automatic run_round(input logic [N-1:0] mask, input int lens[N], input int lasts[N],
                            input int qos[N]);
      start_round(mask, lens, lasts, qos);
      finish_round();
   endtask

   initial begin : main
      int lens[N];
      int lasts[N];
      int qos[N];
      int zq[N];
      int guard;
      logic [N-1:0] mask;

      for (int i = 0; i < N; i++) begin
         aw_pend[i] = 1'b0; w_part[i] = 1'b0; beats[i] = 0;
         len_m[i] = 0; last_m[i] = 0; qos_m[i] = 0; zq[i] = 0;
      end

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // All four masters with single-beat bursts, twice: 0,1,2,3 then 0,1,2,3.
      run_round(4'b1111, '{0, 0, 0, 0}, '{0, 0, 0, 0}, zq);
      run_round(4'b1111, '{0, 0, 0, 0}, '{0, 0, 0, 0}, zq);

      // Single master 2, four beats.
      run_round(4'b0100, '{0, 0, 3, 0}, '{0, 0, 3, 0}, zq);

      // Master 1 ends its 4-beat burst after beat 2: sticky error.
      run_round(4'b0010, '{0, 3, 0, 0}, '{0, 1, 0, 0}, zq);
      // Clean burst afterwards: error stays set.
      run_round(4'b0001, '{2, 0, 0, 0}, '{2, 0, 0, 0}, zq);

      // AWREADY held low 5 cycles, BVALID 3 cycles late, two masters competing.
      aw_stall = 5;
      b_fixed  = 3;
      run_round(4'b1010, '{0, 2, 0, 3}, '{0, 2, 0, 3}, zq);
      b_fixed  = -1;

      // Randomized rounds, occasional early or late WLAST.
      for (int r = 0; r < 25; r++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            lens[i]  = $urandom_range(0, 3);
            lasts[i] = lens[i];
            if ($urandom_range(0, 5) == 0) begin
               lasts[i] = (lens[i] > 0 && $urandom_range(0, 1) == 1) ? lens[i] - 1 : lens[i] + 1;
            end
`ifdef AXI_ARB_QOS_EN
            qos[i] = $urandom_range(0, 15);
`else
            qos[i] = 0;
`endif
         end
         run_round(mask, lens, lasts, qos);
      end

`ifdef AXI_ARB_QOS_EN
      // Master 3 at QoS 9 beats master 0 at QoS 2 regardless of the pointer.
      run_round(4'b1001, '{1, 0, 0, 1}, '{1, 0, 0, 1}, '{2, 0, 0, 9});
`endif

      // Reset in the middle of a burst from master 1.
      start_round(4'b0010, '{0, 3, 0, 0}, '{0, 3, 0, 0}, zq);
      guard = 0;
      while (beats[1] < 1 && guard < 1000) begin
         @(posedge clk);
         guard++;
      end
      check("reach_data_beat1", beats[1] >= 1, 1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         aw_pend[i] = 1'b0; w_part[i] = 1'b0; beats[i] = 0;
      end
      b_pend = 1'b0;
      outstanding = 0;
      rr_model = 0;
      err_model = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check_all_zero("held_reset");
      @(negedge clk);
      rst = 1'b0;

      // Pointer back at 0: master 0 first, then master 2.
      run_round(4'b0101, '{1, 0, 2, 0}, '{1, 0, 2, 0}, zq);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
